// File: rtl/alu_sequencer.sv
// Initiator for the registered ALU: accepts one command at a time, holds the operands
// for the ALU latency, and returns the captured result. ALU_SEQ_CHAIN_EN enables result chaining.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | first cycle after reset, ALU held in clear
// IDLE  | ready for a command
// WAIT  | operands held on the ALU, counting down its latency
// HOLD  | response presented, waiting for the consumer
module alu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [2:0]       alu_opCode,
    output logic [WIDTH-1:0] alu_inputA,
    output logic [WIDTH-1:0] alu_inputB,
    output logic             alu_clear,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_CNT = CW'(LATENCY);

    logic [1:0]       state;
    logic [CW-1:0]    wait_cnt;
    logic             op_legal;
    logic             capture;
    logic [WIDTH-1:0] next_a;

    assign op_legal = (cmd_op <= 3'd4);
    assign capture  = (state == ST_WAIT) && (wait_cnt == '0);

`ifdef ALU_SEQ_CHAIN_EN
    logic [WIDTH-1:0] chain_q;

    // Tracks the last legal result; illegal commands never reach WAIT so they leave it alone.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            chain_q <= '0;
        end else if (capture) begin
            chain_q <= alu_result;
        end
    end

    assign next_a = cmd_chain ? chain_q : cmd_a;
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign next_a       = cmd_a;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= ST_INIT;
            wait_cnt   <= '0;
            cmd_ready  <= 1'b0;
            alu_opCode <= 3'd0;
            alu_inputA <= '0;
            alu_inputB <= '0;
            alu_clear  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    alu_clear <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (op_legal) begin
                            alu_opCode <= cmd_op;
                            alu_inputA <= next_a;
                            alu_inputB <= cmd_b;
                            wait_cnt   <= LAT_CNT;
                            state      <= ST_WAIT;
                        end else begin
                            // ALU operands stay as they were; the error response skips WAIT.
                            rsp_result <= '0;
                            rsp_zero   <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered ALU model attached.
module tb_alu_sequencer;

    localparam int WIDTH = 32;

    logic             clock;
    logic             clear;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_chain;
    logic [2:0]       alu_opCode;
    logic [WIDTH-1:0] alu_inputA;
    logic [WIDTH-1:0] alu_inputB;
    logic             alu_clear;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_chain_a;
    logic [WIDTH-1:0] exp_chain_res;

    alu_sequencer #(.WIDTH(WIDTH), .LATENCY(1)) dut (
        .clock      (clock),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .alu_opCode (alu_opCode),
        .alu_inputA (alu_inputA),
        .alu_inputB (alu_inputB),
        .alu_clear  (alu_clear),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Registered ALU: result appears one edge after the operands.
    always @(posedge clock) begin
        if (alu_clear) begin
            alu_result <= '0;
            alu_zero   <= 1'b1;
        end else begin
            alu_result <= alu_f(alu_opCode, alu_inputA, alu_inputB);
            alu_zero   <= (alu_f(alu_opCode, alu_inputA, alu_inputB) == '0);
        end
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic chain);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        tick();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_zero"}, rsp_zero, 1);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_alu_op"}, alu_opCode, 0);
        check({tag, "_alu_a"}, alu_inputA, 0);
        check({tag, "_alu_b"}, alu_inputB, 0);
        check({tag, "_alu_clear"}, alu_clear, 1);
    endtask

    initial begin
`ifdef ALU_SEQ_CHAIN_EN
        exp_chain_a   = 32'd7;
        exp_chain_res = 32'd17;
`else
        exp_chain_a   = 32'd100;
        exp_chain_res = 32'd110;
`endif
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_chain = 1'b0;
        rsp_ready = 1'b0;

        // Reset and release
        #12;
        check_reset_values("rst");
        tick();
        clear = 1'b0;
        check("init_alu_clear", alu_clear, 1);
        check("init_cmd_ready", cmd_ready, 0);
        tick();
        check("idle_alu_clear", alu_clear, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_zero", rsp_zero, 1);
        check("idle_rsp_result", rsp_result, 0);

        // Add 5+7, consumer always ready
        rsp_ready = 1'b1;
        issue(3'd0, 32'd5, 32'd7, 1'b0);
        check("add_cmd_ready", cmd_ready, 0);
        check("add_alu_op", alu_opCode, 0);
        check("add_alu_a0", alu_inputA, 5);
        check("add_alu_b0", alu_inputB, 7);
        check("add_valid0", rsp_valid, 0);
        tick();
        check("add_valid1", rsp_valid, 0);
        check("add_alu_a1", alu_inputA, 5);
        check("add_alu_b1", alu_inputB, 7);
        tick();
        check("add_valid2", rsp_valid, 1);
        check("add_result", rsp_result, 12);
        check("add_zero", rsp_zero, 0);
        check("add_err", rsp_err, 0);
        tick();
        check("add_valid_drop", rsp_valid, 0);
        check("add_back_idle", cmd_ready, 1);
        check("add_result_kept", rsp_result, 12);

        // Sub to zero with backpressure; a command offered during HOLD must be ignored
        rsp_ready = 1'b0;
        issue(3'd1, 32'h1234, 32'h1234, 1'b0);
        tick();
        tick();
        check("sub_valid", rsp_valid, 1);
        check("sub_result", rsp_result, 0);
        check("sub_zero", rsp_zero, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_a     = 32'd9;
        cmd_b     = 32'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sub_hold_valid", rsp_valid, 1);
            check("sub_hold_result", rsp_result, 0);
            check("sub_hold_zero", rsp_zero, 1);
            check("sub_hold_ready", cmd_ready, 0);
            check("sub_hold_alu_a", alu_inputA, 32'h1234);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("sub_release_valid", rsp_valid, 0);
        check("sub_release_ready", cmd_ready, 1);

        // Illegal opcode, then a legal AND clears the error
        issue(3'd6, 32'd1, 32'd2, 1'b0);
        check("ill_valid", rsp_valid, 1);
        check("ill_result", rsp_result, 0);
        check("ill_zero", rsp_zero, 1);
        check("ill_err", rsp_err, 1);
        check("ill_alu_op", alu_opCode, 1);
        check("ill_alu_a", alu_inputA, 32'h1234);
        rsp_ready = 1'b1;
        tick();
        check("ill_release", rsp_valid, 0);
        check("ill_ready", cmd_ready, 1);
        issue(3'd2, 32'hF0, 32'h3C, 1'b0);
        check("and_alu_op", alu_opCode, 2);
        tick();
        tick();
        check("and_valid", rsp_valid, 1);
        check("and_result", rsp_result, 32'h30);
        check("and_err", rsp_err, 0);
        check("and_zero", rsp_zero, 0);
        tick();

        // Chained add: A comes from the previous result only when the feature is built in
        issue(3'd0, 32'd3, 32'd4, 1'b0);
        tick();
        tick();
        check("chain1_result", rsp_result, 7);
        tick();
        issue(3'd0, 32'd100, 32'd10, 1'b1);
        check("chain2_alu_a", alu_inputA, exp_chain_a);
        tick();
        tick();
        check("chain2_valid", rsp_valid, 1);
        check("chain2_result", rsp_result, exp_chain_res);
        tick();

        // Reset in the second WAIT cycle drops the command
        issue(3'd0, 32'd1, 32'd1, 1'b0);
        tick();
        clear = 1'b1;
        #1;
        check_reset_values("midwait");
        tick();
        clear = 1'b0;
        check("midwait_init_clear", alu_clear, 1);
        tick();
        check("midwait_idle_clear", alu_clear, 0);
        check("midwait_idle_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midwait_no_rsp", rsp_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
